// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage ALU with iterative RISC-V M-extension unit.
// Single-cycle ops finish on the acceptance edge. MUL/DIV family runs a
// shift-add multiplier or restoring divider one bit per cycle.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. in_ready is high only in IDLE and out_valid only in DONE, so
// acceptance and delivery can never coincide. Once out_valid rises,
// ALUResult/Zero stay frozen until out_ready is seen.
module alu_mdu #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     Zero,
  output logic [1:0]               dbg_state
);
  localparam int W   = DATA_WIDTH;
  localparam int SHW = $clog2(DATA_WIDTH);

  typedef logic [OPCODE_LENGTH-1:0] op_t;
  localparam op_t OP_AND   = op_t'(8'h00);
  localparam op_t OP_SUB   = op_t'(8'h01);
  localparam op_t OP_ADD   = op_t'(8'h02);
  localparam op_t OP_OR    = op_t'(8'h03);
  localparam op_t OP_XOR   = op_t'(8'h04);
  localparam op_t OP_SLL   = op_t'(8'h05);
  localparam op_t OP_SRL   = op_t'(8'h06);
  localparam op_t OP_SRA   = op_t'(8'h07);
  localparam op_t OP_EQ    = op_t'(8'h08);
  localparam op_t OP_SLT   = op_t'(8'h09);
  localparam op_t OP_SLTU  = op_t'(8'h0A);
  localparam op_t OP_MUL   = op_t'(8'h10);
  localparam op_t OP_MULH  = op_t'(8'h11);
  localparam op_t OP_MULHU = op_t'(8'h12);
  localparam op_t OP_DIV   = op_t'(8'h13);
  localparam op_t OP_DIVU  = op_t'(8'h14);
  localparam op_t OP_REM   = op_t'(8'h15);
  localparam op_t OP_REMU  = op_t'(8'h16);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_nx;

  // Captured operation and working registers. hi/lo/mcand double as
  // {partial product, multiplier} or {remainder, dividend/quotient}.
  op_t               op_q;
  logic [W-1:0]      a_q, b_q, hi_q, lo_q, mcand_q;
  logic [SHW-1:0]    cnt_q;

  logic              in_iter, in_signed, last_iter, mul_op;
  logic [SHW-1:0]    shamt;
  logic [W-1:0]      single_res, a_mag, b_mag, iter_res;
  logic [W:0]        mul_sum, div_shift, div_diff;
  logic [W-1:0]      mul_hi_nx, mul_lo_nx, div_hi_nx, div_lo_nx, quo, rmd;
  logic [2*W-1:0]    prod;
  logic              div_ok, mul_neg, q_neg, r_neg, b_zero;

  // Classify the incoming opcode and form operand magnitudes for loading.
  always_comb begin
    in_iter   = (Operation == OP_MUL)  || (Operation == OP_MULH) ||
                (Operation == OP_MULHU) || (Operation == OP_DIV) ||
                (Operation == OP_DIVU) || (Operation == OP_REM) ||
                (Operation == OP_REMU);
    in_signed = (Operation == OP_MULH) || (Operation == OP_DIV) ||
                (Operation == OP_REM);
    a_mag     = (in_signed && SrcA[W-1]) ? -SrcA : SrcA;
    b_mag     = (in_signed && SrcB[W-1]) ? -SrcB : SrcB;
  end

  // Single-cycle result; unknown codes (including iterative ones, which
  // never use this path) fall through to 1.
  always_comb begin
    shamt = SrcB[SHW-1:0];
    case (Operation)
      OP_AND:  single_res = SrcA & SrcB;
      OP_SUB:  single_res = SrcA - SrcB;
      OP_ADD:  single_res = SrcA + SrcB;
      OP_OR:   single_res = SrcA | SrcB;
      OP_XOR:  single_res = SrcA ^ SrcB;
      OP_SLL:  single_res = SrcA << shamt;
      OP_SRL:  single_res = SrcA >> shamt;
      OP_SRA:  single_res = W'($signed(SrcA) >>> shamt);
      OP_EQ:   single_res = W'(SrcA == SrcB);
      OP_SLT:  single_res = W'($signed(SrcA) < $signed(SrcB));
      OP_SLTU: single_res = W'(SrcA < SrcB);
      default: single_res = W'(1);
    endcase
  end

  // One multiplier/divider step plus the sign fix-up applied on the last one.
  always_comb begin
    mul_op    = (op_q == OP_MUL) || (op_q == OP_MULH) || (op_q == OP_MULHU);
    mul_neg   = (op_q == OP_MULH) && (a_q[W-1] ^ b_q[W-1]);
    q_neg     = (op_q == OP_DIV) && (a_q[W-1] ^ b_q[W-1]);
    r_neg     = (op_q == OP_REM) && a_q[W-1];
    b_zero    = (b_q == '0);
    last_iter = (cnt_q == SHW'(W - 1));

    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    mul_hi_nx = mul_sum[W:1];
    mul_lo_nx = {mul_sum[0], lo_q[W-1:1]};
    prod      = {mul_hi_nx, mul_lo_nx};
    if (mul_neg) prod = -prod;

    div_shift = {hi_q, lo_q[W-1]};
    div_diff  = div_shift - {1'b0, mcand_q};
    div_ok    = ~div_diff[W];
    div_hi_nx = div_ok ? div_diff[W-1:0] : div_shift[W-1:0];
    div_lo_nx = {lo_q[W-2:0], div_ok};
    quo       = q_neg ? -div_lo_nx : div_lo_nx;
    rmd       = r_neg ? -div_hi_nx : div_hi_nx;

    case (op_q)
      OP_MUL:            iter_res = prod[W-1:0];
      OP_MULH, OP_MULHU: iter_res = prod[2*W-1:W];
      OP_DIV, OP_DIVU:   iter_res = b_zero ? '1 : quo;
      OP_REM, OP_REMU:   iter_res = b_zero ? a_q : rmd;
      default:           iter_res = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_nx;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx  = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = in_iter ? S_BUSY : S_DONE;
      end
      S_BUSY: if (last_iter) state_nx = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    dbg_state = state_q;
  end

  // Datapath: capture on acceptance, iterate in BUSY, hold in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      ALUResult <= '0;
      Zero      <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          op_q <= Operation;
          a_q  <= SrcA;
          b_q  <= SrcB;
          if (in_iter) begin
            hi_q    <= '0;
            lo_q    <= a_mag;
            mcand_q <= b_mag;
            cnt_q   <= '0;
          end else begin
            ALUResult <= single_res;
            Zero      <= (single_res == '0);
          end
        end
        S_BUSY: begin
          hi_q  <= mul_op ? mul_hi_nx : div_hi_nx;
          lo_q  <= mul_op ? mul_lo_nx : div_lo_nx;
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) begin
            ALUResult <= iter_res;
            Zero      <= (iter_res == '0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: three instances (8/32/64 bit) share stimulus buses;
// sel_w routes in_valid and picks which instance's outputs are observed.
`timescale 1ns/1ps
module tb_alu_mdu;
  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  int errors = 0;
  int checks = 0;

  logic        iv, out_ready;
  int          sel_w;
  logic [63:0] src_a, src_b;
  logic [4:0]  op_in;

  logic iv8, ir8, ov8, z8;    logic [7:0]  r8;  logic [1:0] st8;
  logic iv32, ir32, ov32, z32; logic [31:0] r32; logic [1:0] st32;
  logic iv64, ir64, ov64, z64; logic [63:0] r64; logic [1:0] st64;

  assign iv8  = iv && (sel_w == 8);
  assign iv32 = iv && (sel_w == 32);
  assign iv64 = iv && (sel_w == 64);

  alu_mdu #(.DATA_WIDTH(8), .OPCODE_LENGTH(5)) dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
    .SrcA(src_a[7:0]), .SrcB(src_b[7:0]), .Operation(op_in),
    .out_valid(ov8), .out_ready(out_ready), .ALUResult(r8), .Zero(z8),
    .dbg_state(st8));
  alu_mdu #(.DATA_WIDTH(32), .OPCODE_LENGTH(5)) dut32 (
    .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32),
    .SrcA(src_a[31:0]), .SrcB(src_b[31:0]), .Operation(op_in),
    .out_valid(ov32), .out_ready(out_ready), .ALUResult(r32), .Zero(z32),
    .dbg_state(st32));
  alu_mdu #(.DATA_WIDTH(64), .OPCODE_LENGTH(5)) dut64 (
    .clk(clk), .reset(reset), .in_valid(iv64), .in_ready(ir64),
    .SrcA(src_a), .SrcB(src_b), .Operation(op_in),
    .out_valid(ov64), .out_ready(out_ready), .ALUResult(r64), .Zero(z64),
    .dbg_state(st64));

  logic        ov_s, ir_s, z_s;
  logic [63:0] res_s;
  always_comb begin
    ov_s = ov32; ir_s = ir32; z_s = z32; res_s = {32'd0, r32};
    if (sel_w == 8) begin
      ov_s = ov8; ir_s = ir8; z_s = z8; res_s = {56'd0, r8};
    end else if (sel_w == 64) begin
      ov_s = ov64; ir_s = ir64; z_s = z64; res_s = r64;
    end
  end

  typedef struct {
    logic [4:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] op, input logic [63:0] a,
                              input logic [63:0] b, input logic [63:0] exp);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp;
    return v;
  endfunction

  // Reference model: plain signed/unsigned arithmetic at width w.
  function automatic logic [63:0] ref_model(input int w, input logic [4:0] op,
                                            input logic [63:0] a_in,
                                            input logic [63:0] b_in);
    logic [63:0] mask, a, b, r, minv;
    longint sa, sb;
    logic signed [127:0] pa, pb, ps;
    logic [127:0] pu;
    int sh;
    logic ovf;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a    = a_in & mask;
    b    = b_in & mask;
    minv = 64'd1 << (w - 1);
    sa   = a[w-1] ? longint'(a | ~mask) : longint'(a);
    sb   = b[w-1] ? longint'(b | ~mask) : longint'(b);
    sh   = int'(b & 64'(w - 1));
    pa   = sa;
    pb   = sb;
    ps   = pa * pb;
    pu   = {64'd0, a} * {64'd0, b};
    ovf  = (a == minv) && (b == mask);
    case (op)
      5'h00: r = a & b;
      5'h01: r = a - b;
      5'h02: r = a + b;
      5'h03: r = a | b;
      5'h04: r = a ^ b;
      5'h05: r = a << sh;
      5'h06: r = a >> sh;
      5'h07: r = 64'(sa >>> sh);
      5'h08: r = {63'd0, a == b};
      5'h09: r = {63'd0, sa < sb};
      5'h0A: r = {63'd0, a < b};
      5'h10: r = ps[63:0];
      5'h11: r = 64'(ps >>> w);
      5'h12: r = 64'(pu >> w);
      5'h13: r = (b == 0) ? '1 : (ovf ? minv : 64'(sa / sb));
      5'h14: r = (b == 0) ? '1 : a / b;
      5'h15: r = (b == 0) ? a : (ovf ? 64'd0 : 64'(sa % sb));
      5'h16: r = (b == 0) ? a : a % b;
      default: r = 64'd1;
    endcase
    return r & mask;
  endfunction

  function automatic logic [63:0] pick_operand(input int w);
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return '1;
      3: return 64'd1 << (w - 1);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Driver: present one op, accept it, scramble inputs, then wait (bounded)
  // for out_valid. Returns at the negedge where the result is visible.
  task automatic issue(input logic [4:0] op, input logic [63:0] a,
                       input logic [63:0] b, output logic [63:0] res,
                       output logic z, output int lat);
    @(negedge clk);
    src_a = a; src_b = b; op_in = op; iv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv = 1'b0;
    src_a = {$urandom, $urandom};
    src_b = {$urandom, $urandom};
    op_in = 5'($urandom);
    lat = 1;
    while (!ov_s && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = res_s;
    z   = z_s;
  endtask

  task automatic test_reset();
    reset = 1'b1; iv = 1'b0; out_ready = 1'b1; sel_w = 32;
    src_a = '0; src_b = '0; op_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++; if (ir32 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", ir32); end
    checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", ov32); end
    checks++; if (r32 !== 32'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", r32); end
    checks++; if (z32 !== 1'b1) begin errors++; $display("FAIL reset_zero got=%b exp=1", z32); end
    checks++; if ({ir8, ov8, z8, r8} !== {1'b1, 1'b0, 1'b1, 8'd0}) begin
      errors++; $display("FAIL reset_w8 got=%b%b%b/%h exp=101/00", ir8, ov8, z8, r8); end
    checks++; if ({ir64, ov64, z64, r64} !== {1'b1, 1'b0, 1'b1, 64'd0}) begin
      errors++; $display("FAIL reset_w64 got=%b%b%b/%h exp=101/0", ir64, ov64, z64, r64); end
    checks++; if (st8 !== st32 || st64 !== st32) begin
      errors++; $display("FAIL reset_state_consistent got=%0d/%0d/%0d exp=equal", st8, st32, st64); end
  endtask

  task automatic test_reset_mid_op();
    logic [63:0] res; logic z; int lat; int seen; logic [1:0] st_idle, st_busy;
    sel_w = 32;
    st_idle = st32;
    @(negedge clk);
    src_a = 64'd7; src_b = 64'd6; op_in = 5'h10; iv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv = 1'b0;
    repeat (5) @(negedge clk);
    st_busy = st32;
    checks++; if (st_busy === st_idle) begin errors++; $display("FAIL busy_state_visible got=%0d idle=%0d", st_busy, st_idle); end
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got=%b exp=0", ov32); end
    checks++; if (ir32 !== 1'b1) begin errors++; $display("FAIL midreset_in_ready got=%b exp=1", ir32); end
    checks++; if (r32 !== 32'd0 || z32 !== 1'b1) begin errors++; $display("FAIL midreset_result got=%h/%b exp=0/1", r32, z32); end
    issue(5'h02, 64'd1, 64'd1, res, z, lat);
    checks++; if (res !== 64'd2) begin errors++; $display("FAIL midreset_add got=%h exp=2", res); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL midreset_add_latency got=%0d exp=1", lat); end
    checks++; if (st32 === st_idle || st32 === st_busy) begin
      errors++; $display("FAIL done_state_visible got=%0d idle=%0d busy=%0d", st32, st_idle, st_busy); end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ov32) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_leftover got=%0d cycles exp=0", seen); end
  endtask

  task automatic test_single();
    vec_t v[$]; logic [63:0] res; logic z; int lat;
    sel_w = 32;
    v.push_back(mk(5'h02, 64'd5, 64'd3, 64'd8));
    v.push_back(mk(5'h01, 64'd3, 64'd5, 64'hFFFF_FFFE));
    v.push_back(mk(5'h07, 64'h8000_0000, 64'h24, 64'hF800_0000));
    v.push_back(mk(5'h09, 64'hFFFF_FFFF, 64'd1, 64'd1));
    v.push_back(mk(5'h0A, 64'hFFFF_FFFF, 64'd1, 64'd0));
    v.push_back(mk(5'h1F, 64'd9, 64'd9, 64'd1));
    v.push_back(mk(5'h00, 64'hF0F0, 64'hFF0F, 64'hF000));
    v.push_back(mk(5'h03, 64'hF0F0, 64'h0F00, 64'hFFF0));
    v.push_back(mk(5'h04, 64'h00FF, 64'h00FF, 64'd0));
    v.push_back(mk(5'h05, 64'd1, 64'h21, 64'd2));
    v.push_back(mk(5'h06, 64'h8000_0000, 64'd31, 64'd1));
    v.push_back(mk(5'h08, 64'd5, 64'd5, 64'd1));
    v.push_back(mk(5'h09, 64'd1, 64'hFFFF_FFFF, 64'd0));
    v.push_back(mk(5'h0A, 64'd1, 64'hFFFF_FFFF, 64'd1));
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b, res, z, lat);
      checks++; if (res !== v[i].exp) begin errors++; $display("FAIL single[%0d] op=%h got=%h exp=%h", i, v[i].op, res, v[i].exp); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL single_latency[%0d] got=%0d exp=1", i, lat); end
      checks++; if (z !== (v[i].exp == 0)) begin errors++; $display("FAIL single_zero[%0d] got=%b exp=%b", i, z, v[i].exp == 0); end
    end
  endtask

  task automatic test_mul();
    vec_t v[$]; logic [63:0] res; logic z; int lat;
    sel_w = 32;
    v.push_back(mk(5'h10, 64'hFFFF_FFFF, 64'd2, 64'hFFFF_FFFE));
    v.push_back(mk(5'h11, 64'hFFFF_FFFE, 64'd3, 64'hFFFF_FFFF));
    v.push_back(mk(5'h12, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE));
    v.push_back(mk(5'h10, 64'd7, 64'd6, 64'd42));
    v.push_back(mk(5'h11, 64'hFFFF_FFFD, 64'hFFFF_FFFB, 64'd0));
    v.push_back(mk(5'h12, 64'h0001_0000, 64'h0001_0000, 64'd1));
    v.push_back(mk(5'h11, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000));
    v.push_back(mk(5'h10, 64'd0, 64'd5, 64'd0));
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b, res, z, lat);
      checks++; if (res !== v[i].exp) begin errors++; $display("FAIL mul[%0d] op=%h got=%h exp=%h", i, v[i].op, res, v[i].exp); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency[%0d] got=%0d exp=33", i, lat); end
      checks++; if (z !== (v[i].exp == 0)) begin errors++; $display("FAIL mul_zero[%0d] got=%b exp=%b", i, z, v[i].exp == 0); end
    end
  endtask

  task automatic test_div();
    vec_t v[$]; logic [63:0] res; logic z; int lat;
    sel_w = 32;
    v.push_back(mk(5'h13, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD));
    v.push_back(mk(5'h15, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF));
    v.push_back(mk(5'h14, 64'd100, 64'd0, 64'hFFFF_FFFF));
    v.push_back(mk(5'h16, 64'd100, 64'd0, 64'd100));
    v.push_back(mk(5'h13, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000));
    v.push_back(mk(5'h15, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0));
    v.push_back(mk(5'h14, 64'd100, 64'd7, 64'd14));
    v.push_back(mk(5'h16, 64'd100, 64'd7, 64'd2));
    v.push_back(mk(5'h13, 64'd7, 64'hFFFF_FFFE, 64'hFFFF_FFFD));
    v.push_back(mk(5'h15, 64'd7, 64'hFFFF_FFFE, 64'd1));
    v.push_back(mk(5'h13, 64'hFFFF_FFF9, 64'd0, 64'hFFFF_FFFF));
    v.push_back(mk(5'h15, 64'hFFFF_FFF9, 64'd0, 64'hFFFF_FFF9));
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b, res, z, lat);
      checks++; if (res !== v[i].exp) begin errors++; $display("FAIL div[%0d] op=%h got=%h exp=%h", i, v[i].op, res, v[i].exp); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency[%0d] got=%0d exp=33", i, lat); end
      checks++; if (z !== (v[i].exp == 0)) begin errors++; $display("FAIL div_zero[%0d] got=%b exp=%b", i, z, v[i].exp == 0); end
    end
  endtask

  task automatic test_backpressure();
    int wait_cnt;
    sel_w = 32;
    @(negedge clk);
    out_ready = 1'b0;
    src_a = 64'd9; src_b = 64'd3; op_in = 5'h14; iv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    src_a = 64'd4; src_b = 64'd5; op_in = 5'h02;
    wait_cnt = 0;
    while (!ov32 && wait_cnt < 200) begin
      checks++; if (ir32 !== 1'b0) begin errors++; $display("FAIL bp_busy_in_ready got=%b exp=0", ir32); end
      @(negedge clk);
      wait_cnt++;
    end
    checks++; if (ov32 !== 1'b1) begin errors++; $display("FAIL bp_timeout out_valid got=%b exp=1", ov32); end
    repeat (5) begin
      checks++; if (r32 !== 32'd3 || ov32 !== 1'b1) begin
        errors++; $display("FAIL bp_hold got=%h/%b exp=3/1", r32, ov32); end
      checks++; if (ir32 !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", ir32); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (ov32 !== 1'b0 || ir32 !== 1'b1) begin
      errors++; $display("FAIL bp_release got ov=%b ir=%b exp ov=0 ir=1", ov32, ir32); end
    @(negedge clk);
    iv = 1'b0;
    checks++; if (ov32 !== 1'b1 || r32 !== 32'd9) begin
      errors++; $display("FAIL bp_second_op got=%h/%b exp=9/1", r32, ov32); end
  endtask

  task automatic test_back_to_back();
    sel_w = 32;
    @(negedge clk);
    iv = 1'b1; op_in = 5'h02; src_b = 64'd1;
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) src_a = 64'(k);
      checks++; if (ir32 !== (k % 2 == 0)) begin errors++; $display("FAIL b2b_in_ready[%0d] got=%b exp=%b", k, ir32, k % 2 == 0); end
      checks++; if (ov32 !== (k % 2 == 1)) begin errors++; $display("FAIL b2b_out_valid[%0d] got=%b exp=%b", k, ov32, k % 2 == 1); end
      if (k % 2 == 1) begin
        checks++; if (r32 !== 32'(k)) begin errors++; $display("FAIL b2b_result[%0d] got=%h exp=%h", k, r32, k); end
      end
      if (k == 9) iv = 1'b0;
      else @(negedge clk);
    end
  endtask

  task automatic test_random();
    int widths[3];
    logic [4:0] op; logic [63:0] a, b, exp, res; logic z; int lat, exp_lat, r;
    widths[0] = 8; widths[1] = 32; widths[2] = 64;
    foreach (widths[wi]) begin
      sel_w = widths[wi];
      for (int n = 0; n < 60; n++) begin
        r = $urandom_range(0, 19);
        if (r <= 10)      op = 5'(r);
        else if (r <= 17) op = 5'(16 + r - 11);
        else if (r == 18) op = 5'h1F;
        else              op = 5'h0B;
        a = pick_operand(sel_w);
        b = pick_operand(sel_w);
        exp = ref_model(sel_w, op, a, b);
        exp_lat = (op >= 5'h10 && op <= 5'h16) ? sel_w + 1 : 1;
        issue(op, a, b, res, z, lat);
        checks++; if (res !== exp) begin
          errors++; $display("FAIL rand_w%0d[%0d] op=%h a=%h b=%h got=%h exp=%h", sel_w, n, op, a, b, res, exp); end
        checks++; if (lat !== exp_lat) begin
          errors++; $display("FAIL rand_latency_w%0d[%0d] op=%h got=%0d exp=%0d", sel_w, n, op, lat, exp_lat); end
        checks++; if (z !== (exp == 0)) begin
          errors++; $display("FAIL rand_zero_w%0d[%0d] got=%b exp=%b", sel_w, n, z, exp == 0); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_op();
    test_single();
    test_mul();
    test_div();
    test_backpressure();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end
endmodule
